// File: rtl/pipelined_select_alu.sv
// Two-stage carry-select add/subtract unit with valid/ready flow control.
// Stage 1 computes the low segment sum and both high-segment candidates
// (carry-in 0 and carry-in 1). Stage 2 picks the candidate that matches the
// registered low carry and derives the signed overflow.
// Optional feature macro: ALU_COMPARE_FLAGS_EN adds the isNotEqual/isLessThan
// compare flags. These flags are only meaningful for subtraction.
module pipelined_select_alu #(
    parameter int WIDTH = 32,
    parameter int LOW_W = WIDTH / 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
`ifdef ALU_COMPARE_FLAGS_EN
    ,
    output logic             isNotEqual,
    output logic             isLessThan
`endif
);

    localparam int HIGH_W = WIDTH - LOW_W;

    logic              s1_adv, s2_adv, accept;
    logic [WIDTH-1:0]  b_eff;
    logic [LOW_W:0]    lo_full;
    logic [HIGH_W:0]   hi0_full, hi1_full;

    logic              s1_valid_d, s1_valid_q;
    logic [LOW_W-1:0]  s1_lo_d, s1_lo_q;
    logic              s1_clo_d, s1_clo_q;
    logic [HIGH_W-1:0] s1_hi0_d, s1_hi0_q, s1_hi1_d, s1_hi1_q;
    logic              s1_co0_d, s1_co0_q, s1_co1_d, s1_co1_q;
    logic              s1_cm0_d, s1_cm0_q, s1_cm1_d, s1_cm1_q;

    logic [HIGH_W-1:0] sel_hi;
    logic              sel_co, sel_cm;
    logic [WIDTH-1:0]  sum_sel;
    logic              ovf_sel;

    logic              s2_valid_d, s2_valid_q;
    logic [WIDTH-1:0]  s2_sum_d, s2_sum_q;
    logic              s2_ovf_d, s2_ovf_q;

`ifdef ALU_COMPARE_FLAGS_EN
    logic              s1_sub_d, s1_sub_q;
    logic              s2_ne_d, s2_ne_q, s2_lt_d, s2_lt_q;
`endif

    // Handshake: a stage advances when it is empty or its successor advances.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
        accept   = in_valid && s1_adv;
    end

    // Stage 1 arithmetic: low sum plus both high candidates. Carry into the
    // MSB is recovered as sum_msb ^ a_msb ^ b_msb, which also covers a 1-bit
    // high segment where the MSB carry-in is the candidate's own carry-in.
    always_comb begin
        b_eff    = b ^ {WIDTH{alu_control}};
        lo_full  = {1'b0, a[LOW_W-1:0]} + {1'b0, b_eff[LOW_W-1:0]}
                 + {{LOW_W{1'b0}}, alu_control};
        hi0_full = {1'b0, a[WIDTH-1:LOW_W]} + {1'b0, b_eff[WIDTH-1:LOW_W]};
        hi1_full = hi0_full + {{HIGH_W{1'b0}}, 1'b1};
    end

    // Stage 1 next state: load on accept, drain when advancing.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_clo_d   = s1_clo_q;
        s1_hi0_d   = s1_hi0_q;
        s1_co0_d   = s1_co0_q;
        s1_cm0_d   = s1_cm0_q;
        s1_hi1_d   = s1_hi1_q;
        s1_co1_d   = s1_co1_q;
        s1_cm1_d   = s1_cm1_q;
`ifdef ALU_COMPARE_FLAGS_EN
        s1_sub_d   = s1_sub_q;
`endif
        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_lo_d  = lo_full[LOW_W-1:0];
            s1_clo_d = lo_full[LOW_W];
            s1_hi0_d = hi0_full[HIGH_W-1:0];
            s1_co0_d = hi0_full[HIGH_W];
            s1_cm0_d = hi0_full[HIGH_W-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
            s1_hi1_d = hi1_full[HIGH_W-1:0];
            s1_co1_d = hi1_full[HIGH_W];
            s1_cm1_d = hi1_full[HIGH_W-1] ^ a[WIDTH-1] ^ b_eff[WIDTH-1];
`ifdef ALU_COMPARE_FLAGS_EN
            s1_sub_d = alu_control;
`endif
        end
    end

    // Stage 2 select: low carry picks the high candidate and its carries.
    always_comb begin
        sel_hi  = s1_clo_q ? s1_hi1_q : s1_hi0_q;
        sel_co  = s1_clo_q ? s1_co1_q : s1_co0_q;
        sel_cm  = s1_clo_q ? s1_cm1_q : s1_cm0_q;
        sum_sel = {sel_hi, s1_lo_q};
        ovf_sel = sel_co ^ sel_cm;
    end

    // Stage 2 next state: hold while stalled so outputs stay stable.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_ovf_d   = s2_ovf_q;
`ifdef ALU_COMPARE_FLAGS_EN
        s2_ne_d    = s2_ne_q;
        s2_lt_d    = s2_lt_q;
`endif
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d = sum_sel;
                s2_ovf_d = ovf_sel;
`ifdef ALU_COMPARE_FLAGS_EN
                s2_ne_d  = s1_sub_q & (|sum_sel);
                s2_lt_d  = s1_sub_q & (sum_sel[WIDTH-1] ^ ovf_sel);
`endif
            end
        end
    end

    // Pipeline registers; reset clears valids and result data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_clo_q   <= 1'b0;
            s1_hi0_q   <= '0;
            s1_co0_q   <= 1'b0;
            s1_cm0_q   <= 1'b0;
            s1_hi1_q   <= '0;
            s1_co1_q   <= 1'b0;
            s1_cm1_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_ovf_q   <= 1'b0;
`ifdef ALU_COMPARE_FLAGS_EN
            s1_sub_q   <= 1'b0;
            s2_ne_q    <= 1'b0;
            s2_lt_q    <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lo_q    <= s1_lo_d;
            s1_clo_q   <= s1_clo_d;
            s1_hi0_q   <= s1_hi0_d;
            s1_co0_q   <= s1_co0_d;
            s1_cm0_q   <= s1_cm0_d;
            s1_hi1_q   <= s1_hi1_d;
            s1_co1_q   <= s1_co1_d;
            s1_cm1_q   <= s1_cm1_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_ovf_q   <= s2_ovf_d;
`ifdef ALU_COMPARE_FLAGS_EN
            s1_sub_q   <= s1_sub_d;
            s2_ne_q    <= s2_ne_d;
            s2_lt_q    <= s2_lt_d;
`endif
        end
    end

    // Outputs come straight from stage 2.
    always_comb begin
        out_valid  = s2_valid_q;
        sum        = s2_sum_q;
        overflow   = s2_ovf_q;
`ifdef ALU_COMPARE_FLAGS_EN
        isNotEqual = s2_ne_q;
        isLessThan = s2_lt_q;
`endif
    end

endmodule

// File: doc/pipelined_select_alu.md
PIPELINED_SELECT_ALU -- requirements
Module: pipelined_select_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal 4..64.
REQ-002 SHALL have parameter LOW_W, default WIDTH/2, width of the low segment; legal 1..WIDTH-1.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have ports a, b  input  WIDTH  operands.
REQ-008 SHALL have port alu_control  input  1  0 = a+b, 1 = a-b.
REQ-009 SHALL have port out_valid  output  1  result beat present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 SHALL have port overflow  output  1  signed two's-complement overflow.
REQ-013 SHALL have ports isNotEqual, isLessThan  output  1 each  compare flags (present only per REQ-030).

Function
REQ-014 SHALL implement a two-stage pipeline, S1 and S2, each holding a valid bit plus data; an input is accepted when in_valid && in_ready.
REQ-015 S1 SHALL register: low sum of a[LOW_W-1:0] + (b ^ {WIDTH{alu_control}}) + alu_control, low carry-out, and two high-segment candidates (carry-in 0 and carry-in 1), each with its carry-out and its carry into bit WIDTH-1.
REQ-016 S2 SHALL select the high candidate using the registered low carry, form sum, and compute overflow = carry_out XOR carry_into_MSB of the selected candidate.
REQ-017 Latency SHALL be exactly 2 cycles from acceptance to out_valid with no backpressure; throughput 1 beat/cycle.
REQ-018 s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational, no dependence on in_valid).
REQ-019 While out_valid && !out_ready, sum/overflow/flags SHALL hold stable; no beat is dropped or duplicated.
REQ-020 Simultaneous accept and emit in one cycle SHALL be legal with a full pipeline; both stages shift.
REQ-021 Beats SHALL exit in acceptance order.
REQ-022 Result SHALL be bit-exact to (a ± b) mod 2^WIDTH for every legal WIDTH/LOW_W pairing, including LOW_W = 1 and LOW_W = WIDTH-1.

Reset
REQ-023 While reset = 0, s1_valid, s2_valid and out_valid SHALL be 0 immediately (asynchronous), independent of clock.
REQ-024 While reset = 0, sum, overflow, isNotEqual and isLessThan SHALL read 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight beats; none appears after release.
REQ-026 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-027 After reset deassertion, the first rising edge SHALL accept a beat normally.

Configuration
REQ-028 Macro ALU_COMPARE_FLAGS_EN SHALL control the compare flags.
REQ-029 Without ALU_COMPARE_FLAGS_EN, ports isNotEqual and isLessThan SHALL not exist and no flag logic is synthesised.
REQ-030 With ALU_COMPARE_FLAGS_EN, when alu_control = 1: isNotEqual = |sum, isLessThan = sum[WIDTH-1] XOR overflow (signed a < b); when alu_control = 0 both SHALL be 0; flags travel aligned with their beat through the pipeline.

Verification
REQ-031 WIDTH=32: a=0x7FFFFFFF, b=1, add -> sum 0x80000000, overflow 1, 2 cycles after accept.
REQ-032 WIDTH=32: a=5, b=9, sub, flags enabled -> sum 0xFFFFFFFC, overflow 0, isNotEqual 1, isLessThan 1; a=b=0x1234 sub -> isNotEqual 0, isLessThan 0.
REQ-033 WIDTH=32: a=0x0000FFFF, b=1, add -> sum 0x00010000 (low carry selects high candidate 1), overflow 0.
REQ-034 Stream 8 beats back-to-back with out_ready toggling 1,0,0,1 repeating -> all 8 results in order, outputs stable while stalled, in_ready 0 only when both stages full and out_ready 0.
REQ-035 Accept 2 beats, assert reset = 0 for half a cycle asynchronously -> out_valid drops immediately, zero results emerge after release, in_ready 1.
REQ-036 WIDTH=8, LOW_W=1 and LOW_W=7: exhaustive a, b, alu_control -> sum and overflow match reference arithmetic model.
